cpu_step_4_redirect: RTL
========================

Name: cpu_step_4_redirect

Overview:
- Step-4 control-transfer resolver; drives the PC-select and PC-load controls back into the step-1 fetch stage.
- Registers a branch/jump decision from step 3 and computes the branch target (pc+1+imm) and the jump target (external address).
- Steers the fetch-stage PC mux and load enable.
- Squashes wrong-path instructions in steps 2-3 for a fixed number of cycles after any taken redirect.

Parameters:
- WIDTH, 32, datapath/address width.
- FLUSH_DEPTH, 2, cycles of squash after a taken redirect (wrong-path slots in steps 2-3); legal range 1..7.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- valid_step_3  input  1  step-3 instruction is valid.
- is_branch_step_3  input  1  conditional branch.
- is_jump_step_3  input  1  unconditional jump to an external address.
- cond_met_step_3  input  1  branch condition evaluated true.
- pc_plus_one_step_3  input  WIDTH  PC+1 of the step-3 instruction.
- imm_step_3  input  WIDTH  sign-extended branch offset.
- ext_addr_step_3  input  WIDTH  jump target.
- stall  input  1  global pipeline stall.
- ext_ADDR_step_4  output  WIDTH  registered jump target.
- pc_plus_one_plus_IMM_step_4  output  WIDTH  registered branch target.
- control_mux_for_PC  output  2  PC-mux select: 0 = pc+1, 1 = branch target, 2 = ext address; 3 is never driven.
- is_load_PC  output  1  PC load enable.
- flush_step_2_3  output  1  squash in-flight instructions in steps 2 and 3.

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = RUN; all WIDTH outputs = 0; control_mux_for_PC = 0.
  - is_load_PC = 0; flush_step_2_3 = 0; flush counter = 0.
- Outputs are registered.
- Accept condition: valid_step_3 & !stall & !flush_step_2_3.
- Decision on accept (priority: jump > branch):
  - jump -> sel = 2.
  - branch & cond_met -> sel = 1.
  - otherwise -> sel = 0.
- Target arithmetic:
  - pc_plus_one_plus_IMM_step_4 = pc_plus_one_step_3 + imm_step_3, modulo 2^WIDTH (wrap, no overflow flag).
  - ext_ADDR_step_4 = ext_addr_step_3.
  - Both are latched only on accept.
- States:
  - RUN:
    - is_load_PC = !stall; control_mux_for_PC = 0.
    - On an accepted taken decision -> REDIRECT next cycle.
  - REDIRECT (exactly one cycle):
    - control_mux_for_PC = sel; is_load_PC = 1; flush_step_2_3 = 1.
    - Counter loads FLUSH_DEPTH-1 -> FLUSH, or -> RUN if FLUSH_DEPTH = 1.
    - Ignores stall: a redirect is never lost.
  - FLUSH:
    - flush_step_2_3 = 1; control_mux_for_PC = 0; is_load_PC = !stall.
    - Counter decrements only when !stall; at 0 -> RUN.
- Latency: step-3 taken decision at edge N -> PC load with the target at edge N+2 (register, then REDIRECT).
- Not-taken branches and non-control instructions produce no state change.
- Taken decisions presented while flush_step_2_3 = 1 are ignored; they are wrong-path.
- is_branch and is_jump both set: jump wins.
- Reset asserted mid-REDIRECT/FLUSH: immediate return to RUN; the pending redirect is discarded.

Optional Feature:
- Macro: CPU_REDIRECT_STATS_EN.
- Defined:
  - Adds outputs taken_count and not_taken_count, each 32 bits, each saturating at 0xFFFFFFFF.
  - They increment on accepted taken and accepted not-taken branches respectively; jumps are excluded.
  - Reset to 0.
- Undefined: ports and counters absent; the rest of the behaviour is identical.

Decomposition:
- Shared package cpu_pkg:
  - PC-select encoding constants PC_SEL_PLUS_ONE = 0, PC_SEL_BRANCH = 1, PC_SEL_EXT = 2.
  - Redirect state enum {RUN, REDIRECT, FLUSH}.
- One natural sub-module: redirect_flush_counter (loadable down-counter with stall-hold and zero flag).

Test Plan:
1. Reset, then release with valid non-control instructions and stall = 0 -> control_mux_for_PC = 0, is_load_PC = 1 every cycle, flush_step_2_3 never asserted.
2. Taken branch, pc_plus_one = 0x10, imm = 0x05 -> two edges later pc_plus_one_plus_IMM_step_4 = 0x15, control_mux_for_PC = 1 for one cycle, flush high for FLUSH_DEPTH = 2 cycles.
3. Taken branch, pc_plus_one = 0xFFFFFFFF, imm = 0x2 -> target wraps to 0x00000001.
4. Jump to ext_addr = 0x40 with is_branch also set and cond_met = 1 -> control_mux_for_PC = 2, ext_ADDR_step_4 = 0x40; a second taken branch during the flush is ignored.
5. stall held high for 3 cycles during FLUSH -> flush extended by 3 cycles, is_load_PC = 0 during the stall; REDIRECT cycle still loads.
6. rst driven low in the REDIRECT cycle -> outputs return to 0 asynchronously and no PC load follows.
   With CPU_REDIRECT_STATS_EN: 3 taken and 2 not-taken branches -> taken_count = 3, not_taken_count = 2.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the step-4 redirect logic: PC-select encodings and redirect FSM states.
package cpu_pkg;

  localparam logic [1:0] PC_SEL_PLUS_ONE = 2'd0;
  localparam logic [1:0] PC_SEL_BRANCH   = 2'd1;
  localparam logic [1:0] PC_SEL_EXT      = 2'd2;

  localparam int FLUSH_CNT_W = 3;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } redirect_state_e;

endpackage

// File: rtl/redirect_flush_counter.sv
// Loadable down-counter for the post-redirect squash window; holds while stalled.
module redirect_flush_counter
  import cpu_pkg::*;
#(
  parameter int CW = FLUSH_CNT_W
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          en_i,
  input  logic          stall_i,
  output logic          zero_o
);

  logic [CW-1:0] count_q;
  logic          dec;

  assign dec = en_i && !stall_i && (count_q != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec) begin
      count_q <= count_q - 1'b1;
    end
  end

  // Flags the decrement that empties the counter, so the caller leaves on that edge.
  assign zero_o = dec && (count_q == CW'(1));

endmodule

// File: rtl/cpu_step_4_redirect.sv
// Step-4 control-transfer resolver: registers branch/jump targets, steers the fetch PC mux and squashes steps 2-3.
// Optional macro CPU_REDIRECT_STATS_EN adds saturating taken / not-taken branch counters.
module cpu_step_4_redirect
  import cpu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_step_3,
  input  logic             is_branch_step_3,
  input  logic             is_jump_step_3,
  input  logic             cond_met_step_3,
  input  logic [WIDTH-1:0] pc_plus_one_step_3,
  input  logic [WIDTH-1:0] imm_step_3,
  input  logic [WIDTH-1:0] ext_addr_step_3,
  input  logic             stall,
  output logic [WIDTH-1:0] ext_ADDR_step_4,
  output logic [WIDTH-1:0] pc_plus_one_plus_IMM_step_4,
  output logic [1:0]       control_mux_for_PC,
  output logic             is_load_PC,
  output logic             flush_step_2_3
`ifdef CPU_REDIRECT_STATS_EN
  ,
  output logic [31:0]      taken_count,
  output logic [31:0]      not_taken_count
`endif
);

  redirect_state_e  state_q;
  logic [WIDTH-1:0] ext_q;
  logic [WIDTH-1:0] tgt_q;
  logic [1:0]       mux_q;
  logic             flush_q;
  logic             run_en_q;
  logic [1:0]       sel_d;
  logic             accept;
  logic             taken;
  logic             cnt_zero;

  assign accept = valid_step_3 && !stall && !flush_q;

  always_comb begin
    sel_d = PC_SEL_PLUS_ONE;
    if (is_jump_step_3) begin
      sel_d = PC_SEL_EXT;
    end else if (is_branch_step_3 && cond_met_step_3) begin
      sel_d = PC_SEL_BRANCH;
    end
  end

  assign taken = (sel_d != PC_SEL_PLUS_ONE);

  redirect_flush_counter #(.CW(FLUSH_CNT_W)) u_flush_cnt (
    .clk_i      (clk),
    .rst_ni     (rst),
    .load_i     (state_q == REDIRECT),
    .load_val_i (FLUSH_CNT_W'(FLUSH_DEPTH - 1)),
    .en_i       (state_q == FLUSH),
    .stall_i    (stall),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= RUN;
      ext_q    <= '0;
      tgt_q    <= '0;
      mux_q    <= PC_SEL_PLUS_ONE;
      flush_q  <= 1'b0;
      run_en_q <= 1'b0;
    end else begin
      run_en_q <= 1'b1;
      if (accept) begin
        ext_q <= ext_addr_step_3;
        tgt_q <= pc_plus_one_step_3 + imm_step_3;
      end
      case (state_q)
        RUN: begin
          if (accept && taken) begin
            state_q <= REDIRECT;
            mux_q   <= sel_d;
            flush_q <= 1'b1;
          end
        end
        REDIRECT: begin
          mux_q <= PC_SEL_PLUS_ONE;
          if (FLUSH_DEPTH == 1) begin
            state_q <= RUN;
            flush_q <= 1'b0;
          end else begin
            state_q <= FLUSH;
          end
        end
        FLUSH: begin
          if (cnt_zero) begin
            state_q <= RUN;
            flush_q <= 1'b0;
          end
        end
        default: begin
          state_q <= RUN;
          mux_q   <= PC_SEL_PLUS_ONE;
          flush_q <= 1'b0;
        end
      endcase
    end
  end

  // The redirect cycle always loads; otherwise the live stall gates the load (held low through reset).
  assign is_load_PC                  = (state_q == REDIRECT) || (run_en_q && !stall);
  assign ext_ADDR_step_4             = ext_q;
  assign pc_plus_one_plus_IMM_step_4 = tgt_q;
  assign control_mux_for_PC          = mux_q;
  assign flush_step_2_3              = flush_q;

`ifdef CPU_REDIRECT_STATS_EN
  logic [31:0] taken_cnt_q;
  logic [31:0] not_taken_cnt_q;
  logic        br_only;

  assign br_only = accept && is_branch_step_3 && !is_jump_step_3;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      taken_cnt_q     <= '0;
      not_taken_cnt_q <= '0;
    end else begin
      if (br_only && cond_met_step_3 && (taken_cnt_q != '1)) begin
        taken_cnt_q <= taken_cnt_q + 32'd1;
      end
      if (br_only && !cond_met_step_3 && (not_taken_cnt_q != '1)) begin
        not_taken_cnt_q <= not_taken_cnt_q + 32'd1;
      end
    end
  end

  assign taken_count     = taken_cnt_q;
  assign not_taken_count = not_taken_cnt_q;
`endif

endmodule
